// File: rtl/uart_word_tx.sv
// Serialises a 32-bit word into four back-to-back UART frames (8N1, or 8E1 when
// UART_WORD_TX_PARITY_EN is defined). Valid/ready input, registered line output.
module uart_word_tx #(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD      = 115_200,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_word,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic [2:0]  state_dbg_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cfg
            $error("uart_word_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    // Handshake: a word is taken on any rising edge where tx_valid and tx_ready
    // are both high; tx_ready is high only in IDLE, so nothing is queued.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
`ifdef UART_WORD_TX_PARITY_EN
        ,
        S_PARITY = 3'd3
`endif
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       shift_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
`ifdef UART_WORD_TX_PARITY_EN
    logic              parity_q;
`endif

    // The byte to go first always sits in [7:0]; shifting right walks all four.
    logic [31:0] word_ordered;
    assign word_ordered = MSB_FIRST ? {tx_word[7:0], tx_word[15:8], tx_word[23:16], tx_word[31:24]}
                                    : tx_word;

    logic bit_done;
    assign bit_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                    if (tx_valid && ready_q) begin
                        shift_q    <= word_ordered;
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[31:1]};
`ifdef UART_WORD_TX_PARITY_EN
                        parity_q  <= shift_q[0];
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[31:1]};
`ifdef UART_WORD_TX_PARITY_EN
                            parity_q  <= parity_q ^ shift_q[0];
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

`ifdef UART_WORD_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= S_START;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign uart_tx     = tx_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule
